// File: rtl/gfp8_pkg.sv
// Shared constants for the GFP8 group dot-product datapath.
// A group is 32 int8 mantissas sharing one 5-bit exponent (bias 15).
// Also provides the exponent-combining helper used by the result stage.
package gfp8_pkg;
  localparam int GFP8_GROUP_SIZE = 32;
  localparam int GFP8_MAN_W      = 8;
  localparam int GFP8_EXP_W      = 5;
  localparam int GFP8_EXP_BIAS   = 15;
  localparam int GFP8_ACC_W      = 32;

  localparam int GFP8_DOT8_LANES = 8;
  localparam int GFP8_DOT8_NUM   = GFP8_GROUP_SIZE / GFP8_DOT8_LANES;
  localparam int GFP8_PROD_W     = 2 * GFP8_MAN_W;
  // 8 products of at most 2^14 each: |sum| <= 2^17, 20 bits signed is ample
  localparam int GFP8_DOT8_W     = 20;
  // 32 products: |sum| <= 2^19 = 524288 needs 21 bits signed
  localparam int GFP8_TREE_W     = 21;
  localparam int GFP8_REXP_W     = 8;

  // Biased exponents combine into an unbiased signed product exponent.
  // Range -30..32; exponents 0 and 31 carry no special meaning.
  function automatic logic signed [GFP8_REXP_W-1:0] gfp8_exp_sum(
    input logic [GFP8_EXP_W-1:0] exp_l,
    input logic [GFP8_EXP_W-1:0] exp_r
  );
    logic [GFP8_REXP_W-1:0] s;
    s = GFP8_REXP_W'(exp_l) + GFP8_REXP_W'(exp_r) - GFP8_REXP_W'(2 * GFP8_EXP_BIAS);
    return signed'(s);
  endfunction
endpackage

// File: rtl/gfp8_group_dot_mlp_if.sv
// Bundle of the group dot-product data signals.
//   exp_left/man_left, exp_right/man_right : operand groups (driven by master)
//   result_mantissa/result_exponent        : registered result (driven by slave)
// master = producer of operands / consumer of results; slave = the datapath.
interface gfp8_group_dot_mlp_if;
  import gfp8_pkg::*;

  logic [GFP8_EXP_W-1:0]                         exp_left;
  logic [GFP8_GROUP_SIZE*GFP8_MAN_W-1:0]         man_left;
  logic [GFP8_EXP_W-1:0]                         exp_right;
  logic [GFP8_GROUP_SIZE*GFP8_MAN_W-1:0]         man_right;
  logic signed [GFP8_ACC_W-1:0]                  result_mantissa;
  logic signed [GFP8_REXP_W-1:0]                 result_exponent;

  modport master (
    output exp_left, man_left, exp_right, man_right,
    input  result_mantissa, result_exponent
  );

  modport slave (
    input  exp_left, man_left, exp_right, man_right,
    output result_mantissa, result_exponent
  );
endinterface

// File: rtl/gfp8_mlp_dot8.sv
// 8-pair signed int8 dot product, purely combinational; sized to map onto a
// single MLP72 block.
//   a_i, b_i : 8 packed signed int8 operands, element k = bits [8k+7:8k]
//   sum_o    : signed sum of the 8 products
module gfp8_mlp_dot8
  import gfp8_pkg::*;
(
  input  logic [GFP8_DOT8_LANES*GFP8_MAN_W-1:0] a_i,
  input  logic [GFP8_DOT8_LANES*GFP8_MAN_W-1:0] b_i,
  output logic signed [GFP8_DOT8_W-1:0]         sum_o
);

  always_comb begin
    logic signed [GFP8_PROD_W-1:0] prod;
    prod  = '0;
    sum_o = '0;
    for (int k = 0; k < GFP8_DOT8_LANES; k++) begin
      prod  = $signed(a_i[GFP8_MAN_W*k +: GFP8_MAN_W]) * $signed(b_i[GFP8_MAN_W*k +: GFP8_MAN_W]);
      sum_o = sum_o + GFP8_DOT8_W'(prod);
    end
  end

endmodule

// File: rtl/gfp8_group_dot_mlp.sv
// GFP8 group dot product: 32 signed int8 pairs -> 32-bit mantissa plus the
// combined signed exponent, registered together with a fixed 1-cycle latency
// and full throughput (no handshake).
//   i_clk, i_reset_n (async, active-low)
//   i_exp_left/i_man_left, i_exp_right/i_man_right : operand groups
//   o_result_mantissa, o_result_exponent           : registered result
// Optional: define GFP8_GROUP_DOT_TRACE_EN for a simulation-only trace of
// nonzero results.
module gfp8_group_dot_mlp
  import gfp8_pkg::*;
#(
  parameter int GROUP_ID = 0
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset_n,
  input  logic [GFP8_EXP_W-1:0]                 i_exp_left,
  input  logic [GFP8_GROUP_SIZE*GFP8_MAN_W-1:0] i_man_left,
  input  logic [GFP8_EXP_W-1:0]                 i_exp_right,
  input  logic [GFP8_GROUP_SIZE*GFP8_MAN_W-1:0] i_man_right,
  output logic signed [GFP8_ACC_W-1:0]          o_result_mantissa,
  output logic signed [GFP8_REXP_W-1:0]         o_result_exponent
);

  localparam int SLICE_W = GFP8_DOT8_LANES * GFP8_MAN_W;

  // GROUP_ID only labels the instance; an out-of-range value elaborates nothing.
  if (GROUP_ID < 0 || GROUP_ID > 3) begin : g_group_id_out_of_range
  end

  logic signed [GFP8_DOT8_W-1:0] part [GFP8_DOT8_NUM];

  for (genvar j = 0; j < GFP8_DOT8_NUM; j++) begin : g_dot8
    gfp8_mlp_dot8 u_dot8 (
      .a_i   (i_man_left [SLICE_W*j +: SLICE_W]),
      .b_i   (i_man_right[SLICE_W*j +: SLICE_W]),
      .sum_o (part[j])
    );
  end

  logic signed [GFP8_TREE_W-1:0] sum_lo, sum_hi, sum_all;
  logic signed [GFP8_ACC_W-1:0]  mant_d, mant_q;
  logic signed [GFP8_REXP_W-1:0] exp_d,  exp_q;

  // Two-level adder tree over the four partial sums.
  always_comb begin
    sum_lo  = GFP8_TREE_W'(part[0]) + GFP8_TREE_W'(part[1]);
    sum_hi  = GFP8_TREE_W'(part[2]) + GFP8_TREE_W'(part[3]);
    sum_all = sum_lo + sum_hi;
    mant_d  = GFP8_ACC_W'(sum_all);
    exp_d   = gfp8_exp_sum(i_exp_left, i_exp_right);
  end

  // Mantissa and exponent share one register stage so they stay paired.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mant_q <= '0;
      exp_q  <= '0;
    end else begin
      mant_q <= mant_d;
      exp_q  <= exp_d;
    end
  end

  assign o_result_mantissa = mant_q;
  assign o_result_exponent = exp_q;

`ifdef GFP8_GROUP_DOT_TRACE_EN
  always @(posedge i_clk) begin
    if (mant_q != '0)
      $display("gfp8 group %0d: exp_l=%0d exp_r=%0d -> M=%0d E=%0d",
               GROUP_ID, i_exp_left, i_exp_right, mant_q, exp_q);
  end
`else
`endif

endmodule

// File: tb/tb_gfp8_group_dot_mlp.sv
// Directed bench for gfp8_group_dot_mlp: reset, corner vectors, lane ordering,
// 16-cycle back-to-back stream and mid-stream asynchronous reset.
module tb_gfp8_group_dot_mlp;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  gfp8_group_dot_mlp_if bus ();

  gfp8_group_dot_mlp #(.GROUP_ID(2)) dut (
    .i_clk             (clk),
    .i_reset_n         (rst_n),
    .i_exp_left        (bus.exp_left),
    .i_man_left        (bus.man_left),
    .i_exp_right       (bus.exp_right),
    .i_man_right       (bus.man_right),
    .o_result_mantissa (bus.result_mantissa),
    .o_result_exponent (bus.result_exponent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] fill(input logic [7:0] b);
    logic [255:0] v;
    for (int k = 0; k < 32; k++) v[8*k +: 8] = b;
    return v;
  endfunction

  // Reference dot product computed element by element.
  function automatic int golden_m(input logic [255:0] l, input logic [255:0] r);
    int  s;
    byte a, b;
    s = 0;
    for (int k = 0; k < 32; k++) begin
      a = l[8*k +: 8];
      b = r[8*k +: 8];
      s += int'(a) * int'(b);
    end
    return s;
  endfunction

  task automatic drive(input logic [4:0] el, input logic [255:0] ml,
                       input logic [4:0] er, input logic [255:0] mr);
    bus.exp_left  = el;
    bus.man_left  = ml;
    bus.exp_right = er;
    bus.man_right = mr;
  endtask

  task automatic test_reset;
    drive(5'd20, fill(8'h11), 5'd21, fill(8'h22));
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.result_mantissa !== 32'sd0) begin
      errors++; $display("FAIL reset_mant: got %0d expected 0", bus.result_mantissa);
    end
    checks++;
    if (bus.result_exponent !== 8'sd0) begin
      errors++; $display("FAIL reset_exp: got %0d expected 0", bus.result_exponent);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_corner(input string name, input logic [4:0] el, input logic [7:0] bl,
                             input logic [4:0] er, input logic [7:0] br,
                             input int exp_m, input int exp_e);
    @(negedge clk);
    drive(el, fill(bl), er, fill(br));
    @(posedge clk);
    #1;
    checks++;
    if (bus.result_mantissa !== 32'(exp_m)) begin
      errors++; $display("FAIL %s_mant: got %0d expected %0d", name, bus.result_mantissa, exp_m);
    end
    checks++;
    if (bus.result_exponent !== 8'(exp_e)) begin
      errors++; $display("FAIL %s_exp: got %0d expected %0d", name, bus.result_exponent, exp_e);
    end
  endtask

  task automatic test_lanes;
    logic [255:0] l, r;
    l = '0; r = '0;
    l[255:248] = 8'h05; r[255:248] = 8'hFD;
    @(negedge clk);
    drive(5'd15, l, 5'd16, r);
    @(posedge clk);
    #1;
    checks++;
    if (bus.result_mantissa !== -32'sd15) begin
      errors++; $display("FAIL lane31_mant: got %0d expected -15", bus.result_mantissa);
    end
    checks++;
    if (bus.result_exponent !== 8'sd1) begin
      errors++; $display("FAIL lane31_exp: got %0d expected 1", bus.result_exponent);
    end
    l = '0; r = '0;
    l[7:0] = 8'hF9; r[7:0] = 8'h09;
    @(negedge clk);
    drive(5'd15, l, 5'd16, r);
    @(posedge clk);
    #1;
    checks++;
    if (bus.result_mantissa !== -32'sd63) begin
      errors++; $display("FAIL lane0_mant: got %0d expected -63", bus.result_mantissa);
    end
  endtask

  task automatic test_back_to_back;
    logic [255:0] l, r;
    logic [4:0]   el, er;
    int           exp_m [16];
    int           exp_e [16];
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 32; k++) begin
        l[8*k +: 8] = 8'((i * 37 + k * 11) & 8'hFF);
        r[8*k +: 8] = 8'((i * 53 + k * 7 + 3) & 8'hFF);
      end
      el = 5'(i * 2);
      er = 5'(31 - i);
      exp_m[i] = golden_m(l, r);
      exp_e[i] = int'(el) + int'(er) - 30;
      @(negedge clk);
      if (i > 0) begin
        // the previous sample must still be held just before the next edge
        checks++;
        if (bus.result_mantissa !== 32'(exp_m[i-1])) begin
          errors++; $display("FAIL b2b_hold[%0d]: got %0d expected %0d", i-1, bus.result_mantissa, exp_m[i-1]);
        end
      end
      drive(el, l, er, r);
      @(posedge clk);
      #1;
      checks++;
      if (bus.result_mantissa !== 32'(exp_m[i])) begin
        errors++; $display("FAIL b2b_mant[%0d]: got %0d expected %0d", i, bus.result_mantissa, exp_m[i]);
      end
      checks++;
      if (bus.result_exponent !== 8'(exp_e[i])) begin
        errors++; $display("FAIL b2b_exp[%0d]: got %0d expected %0d", i, bus.result_exponent, exp_e[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    drive(5'd15, fill(8'h01), 5'd15, fill(8'h01));
    @(posedge clk);
    #1;
    checks++;
    if (bus.result_mantissa !== 32'sd32) begin
      errors++; $display("FAIL mid_pre_mant: got %0d expected 32", bus.result_mantissa);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.result_mantissa !== 32'sd0 || bus.result_exponent !== 8'sd0) begin
      errors++; $display("FAIL mid_async_clear: got M=%0d E=%0d expected 0/0", bus.result_mantissa, bus.result_exponent);
    end
    drive(5'd16, fill(8'h02), 5'd17, fill(8'hFF));
    @(posedge clk);
    #1;
    checks++;
    if (bus.result_mantissa !== 32'sd0) begin
      errors++; $display("FAIL mid_held: got %0d expected 0", bus.result_mantissa);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.result_mantissa !== 32'sd0) begin
      errors++; $display("FAIL mid_release_pre_edge: got %0d expected 0", bus.result_mantissa);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.result_mantissa !== -32'sd64) begin
      errors++; $display("FAIL mid_first_mant: got %0d expected -64", bus.result_mantissa);
    end
    checks++;
    if (bus.result_exponent !== 8'sd3) begin
      errors++; $display("FAIL mid_first_exp: got %0d expected 3", bus.result_exponent);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_corner("ones", 5'd15, 8'h01, 5'd15, 8'h01, 32, 0);
    test_corner("min",  5'd31, 8'h80, 5'd31, 8'h80, 524288, 32);
    test_corner("mixed", 5'd0, 8'h7F, 5'd0, 8'h80, -520192, -30);
    test_lanes();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/gfp8_group_dot_mlp.md
GFP8_GROUP_DOT_MLP -- requirements
Module: gfp8_group_dot_mlp

Interface
REQ-001 SHALL have parameter: GROUP_ID, default 0, group index (0..3); informational only, no effect on arithmetic.
REQ-002 SHALL have port: i_clk  input  1  clock, rising-edge.
REQ-003 SHALL have port: i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_exp_left  input  5  left group exponent, unsigned, bias 15.
REQ-005 SHALL have port: i_man_left  input  256  32 left mantissas, signed int8; element k = bits [8k+7:8k].
REQ-006 SHALL have port: i_exp_right  input  5  right group exponent, unsigned, bias 15.
REQ-007 SHALL have port: i_man_right  input  256  32 right mantissas, same packing as left.
REQ-008 SHALL have port: o_result_mantissa  output  32  signed dot-product mantissa, registered.
REQ-009 SHALL have port: o_result_exponent  output  8  signed result exponent, registered.

Function
REQ-010 SHALL compute M = sum over k=0..31 of signed(man_left[k]) * signed(man_right[k]); products 16-bit signed, accumulation at least 21-bit, sign-extended to 32 bits; no overflow possible (|M| <= 524288).
REQ-011 SHALL compute E = i_exp_left + i_exp_right - 30 as 8-bit signed (range -30..32); no special encoding for exponent 0 or 31.
REQ-012 SHALL have fixed latency of exactly 1 clock: outputs at edge N+1 reflect inputs sampled at edge N.
REQ-013 SHALL have no valid/ready handshake; it SHALL sample inputs on every rising edge and update outputs every cycle (full throughput, one result per clock).
REQ-014 SHALL register mantissa and exponent together so both outputs always belong to the same input sample.
REQ-015 SHALL keep the combinational path between input ports and the output registers free of any other state; no accumulation across cycles.

Reset
REQ-016 SHALL, while i_reset_n is low, drive o_result_mantissa = 0 and o_result_exponent = 0 immediately (asynchronous), independent of clock.
REQ-017 SHALL, on reset deassertion, produce the first valid result at the first rising edge after release from inputs present at that edge; reset asserted mid-stream SHALL discard the in-flight result.

Configuration
REQ-018 SHALL support macro GFP8_GROUP_DOT_TRACE_EN: when defined, a simulation-only per-cycle message prints GROUP_ID, exponents and registered result whenever the result is nonzero; when undefined, no trace code is compiled and RTL is functionally identical.

Structure
REQ-019 SHALL take constants from shared package gfp8_pkg: GFP8_GROUP_SIZE=32, GFP8_MAN_W=8, GFP8_EXP_W=5, GFP8_EXP_BIAS=15, GFP8_ACC_W=32.
REQ-020 SHALL build the dot product from 4 instances of sub-module gfp8_mlp_dot8 (8-pair signed int8 dot product, combinational, mappable to one MLP72 block), elements 8j..8j+7 to instance j, partial sums added in an adder tree.
REQ-021 SHALL contain no other sub-modules; the exponent adder and output registers live in the top module.

Verification
REQ-022 SHALL test: all mantissas 0x01 both sides, exps 15/15 -> next cycle M=32, E=0.
REQ-023 SHALL test: all mantissas 0x80 (-128) both sides, exps 31/31 -> M=524288, E=32.
REQ-024 SHALL test: left all 0x7F, right all 0x80, exps 0/0 -> M=-520192, E=-30.
REQ-025 SHALL test lane ordering: only element 31 nonzero (left 5, right 0xFD=-3), then only element 0 (left -7, right 9) -> M=-15 then M=-63.
REQ-026 SHALL test back-to-back: a different vector every cycle for 16 cycles -> each output equals the prior cycle's golden result, with no bubbles.
REQ-027 SHALL test: assert i_reset_n low between edges mid-stream -> outputs 0 at once; release -> first result after the next edge.
